dmac_channel_ctrl: RTL and testbench
====================================

DMAC_CHANNEL_CTRL -- requirements
Module: dmac_channel_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have inputs: channel_en 1 (start request); bs0, tslb, ts0, fifo_full, fifo_empty 1 each (datapath status); mburst_size 3 (encoded burst: 000=1, 001=4, 010=8, 011=16 beats; others=1); hgrant 1; hready 1; hresp 1 (1=ERROR).
REQ-003 SHALL have datapath-control outputs, 1 bit each: s_sel, d_sel, b_sel, t_sel, s_en, d_en, ts_en, sz_en, burst_en, count_en, h_sel, wr_en, rd_en, trigger.
REQ-004 SHALL have bus outputs: hbusreq 1; htrans 2 (00 IDLE, 10 NONSEQ, 11 SEQ); hwrite 1.
REQ-005 SHALL have status outputs: busy 1; done_irq 1; err_irq 1.

Function
REQ-006 SHALL implement states IDLE, CONFIG, CHECK, REQ, READ, WRITE, UPDATE, DONE, ERROR; all outputs Moore-decoded except where beat-qualified below.
REQ-007 SHALL start only on a rising edge of channel_en detected in IDLE (registered previous value); levels or edges in other states are ignored.
REQ-008 CONFIG (1 cycle): s_en=d_en=ts_en=sz_en=burst_en=1, s_sel=d_sel=t_sel=1, b_sel=0; next CHECK.
REQ-009 CHECK (1 cycle): ts0=1 -> DONE; else tslb=1 and single-mode flag clear -> burst_en=1, b_sel=1, set single-mode flag, stay in CHECK one further cycle; else -> REQ.
REQ-010 Beat length SHALL be mburst_size decoded (5-bit internal), forced to 1 when the single-mode flag is set; the internal beat counter SHALL load this value on entry to READ and on entry to WRITE.
REQ-011 REQ: hbusreq=1 until hgrant=1 sampled high; then READ. hbusreq SHALL remain 1 through READ and WRITE, and SHALL be 0 otherwise.
REQ-012 READ: h_sel=0, hwrite=0; a beat completes in a cycle with hready=1 and fifo_full=0; on that cycle wr_en=1, s_en=1 (s_sel=0), count_en=1, beat counter decrements.
REQ-013 htrans SHALL be NONSEQ on the first beat of a READ or WRITE burst, SEQ on later beats, IDLE in all other states and while stalled on fifo_full/fifo_empty.
REQ-014 After the last READ beat completes -> WRITE; beat counter reloads.
REQ-015 WRITE: h_sel=1, hwrite=1, trigger=1; a beat completes when hready=1 and fifo_empty=0; on that cycle rd_en=1, d_en=1 (d_sel=0), count_en=1.
REQ-016 After the last WRITE beat -> UPDATE (1 cycle): ts_en=1, t_sel=0; next CHECK.
REQ-017 DONE (1 cycle): done_irq=1, single-mode flag cleared; next IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 A stall (hready=0 or FIFO guard) SHALL hold all enables low and the beat counter unchanged.
REQ-020 Enables not listed for a state SHALL be 0; sel outputs not listed SHALL be 0.

Reset
REQ-021 rst=1 on a clock edge SHALL force IDLE, clear beat counter, single-mode flag, and edge register, in any state including mid-burst.
REQ-022 During and after reset, until the first start, every output SHALL be 0.

Configuration
REQ-023 Macro DMAC_CHCTRL_ERR_EN defined: hresp=1 with hready=1 in READ or WRITE SHALL go to ERROR, which asserts err_irq=1 and holds all other outputs 0 until channel_en=0, then IDLE.
REQ-024 Macro DMAC_CHCTRL_ERR_EN undefined: the hresp port SHALL remain but be ignored; ERROR is unreachable; err_irq SHALL be constant 0.

Verification
REQ-025 Reset mid-READ (2 beats into 8-beat burst) -> next cycle IDLE, all outputs 0, busy=0.
REQ-026 Start, mburst_size=001, ts goes 8 -> 4 -> 0, hready=1, hgrant=1 -> two READ/WRITE pairs of 4 beats each, htrans 10,11,11,11 per burst, done_irq one cycle.
REQ-027 tslb=1 at CHECK, ts0=0 -> b_sel=1 and burst_en=1 for one cycle, then 1-beat READ and WRITE bursts with htrans=10 only.
REQ-028 hready=0 for 3 cycles on READ beat 2 -> wr_en, s_en, count_en low and htrans=00 for those 3 cycles; beat resumes, total wr_en pulses=4.
REQ-029 fifo_empty=1 during WRITE beat 1 -> rd_en=0, trigger=1, no d_en until fifo_empty=0.
REQ-030 With DMAC_CHCTRL_ERR_EN: hresp=1, hready=1 on WRITE beat 3 -> ERROR, err_irq=1 held until channel_en=0; without macro same stimulus -> normal completion, err_irq=0.

Source files
------------

// File: rtl/dmac_channel_ctrl.sv
// DMA channel controller: sequences config, AHB read/write bursts and per-burst update.
// Optional AHB ERROR response handling is enabled by defining DMAC_CHCTRL_ERR_EN.
module dmac_channel_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_channel_en,
    input  logic       i_bs0,
    input  logic       i_tslb,
    input  logic       i_ts0,
    input  logic       i_fifo_full,
    input  logic       i_fifo_empty,
    input  logic [2:0] i_mburst_size,
    input  logic       i_hgrant,
    input  logic       i_hready,
    input  logic       i_hresp,
    output logic       o_s_sel,
    output logic       o_d_sel,
    output logic       o_b_sel,
    output logic       o_t_sel,
    output logic       o_s_en,
    output logic       o_d_en,
    output logic       o_ts_en,
    output logic       o_sz_en,
    output logic       o_burst_en,
    output logic       o_count_en,
    output logic       o_h_sel,
    output logic       o_wr_en,
    output logic       o_rd_en,
    output logic       o_trigger,
    output logic       o_hbusreq,
    output logic [1:0] o_htrans,
    output logic       o_hwrite,
    output logic       o_busy,
    output logic       o_done_irq,
    output logic       o_err_irq
);

    typedef enum logic [3:0] {
        StIdle,
        StConfig,
        StCheck,
        StReq,
        StRead,
        StWrite,
        StUpdate,
        StDone,
        StError
    } state_e;

    localparam logic [1:0] HtIdle   = 2'b00;
    localparam logic [1:0] HtNonseq = 2'b10;
    localparam logic [1:0] HtSeq    = 2'b11;

    state_e     r_state;
    state_e     w_state_nxt;
    logic       r_en_prev;
    logic       r_single;
    logic       w_single_nxt;
    logic       r_first;
    logic       w_first_nxt;
    logic [4:0] r_beat_cnt;
    logic [4:0] w_beat_cnt_nxt;
    logic [4:0] w_beat_len;
    logic       w_rd_beat;
    logic       w_wr_beat;
    logic       w_err;
    logic       w_unused;

    // Status input not needed for sequencing; hresp is only consumed with the error option.
    assign w_unused = ^{i_bs0, i_hresp};

    always_comb begin
        w_beat_len = 5'd1;
        if (!r_single) begin
            unique case (i_mburst_size)
                3'b001:  w_beat_len = 5'd4;
                3'b010:  w_beat_len = 5'd8;
                3'b011:  w_beat_len = 5'd16;
                default: w_beat_len = 5'd1;
            endcase
        end
    end

    assign w_rd_beat = i_hready && !i_fifo_full;
    assign w_wr_beat = i_hready && !i_fifo_empty;

`ifdef DMAC_CHCTRL_ERR_EN
    assign w_err = i_hresp && i_hready;
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_en_prev  <= 1'b0;
            r_single   <= 1'b0;
            r_first    <= 1'b0;
            r_beat_cnt <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_en_prev  <= i_channel_en;
            r_single   <= w_single_nxt;
            r_first    <= w_first_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_single_nxt   = r_single;
        w_first_nxt    = r_first;
        w_beat_cnt_nxt = r_beat_cnt;
        o_s_sel        = 1'b0;
        o_d_sel        = 1'b0;
        o_b_sel        = 1'b0;
        o_t_sel        = 1'b0;
        o_s_en         = 1'b0;
        o_d_en         = 1'b0;
        o_ts_en        = 1'b0;
        o_sz_en        = 1'b0;
        o_burst_en     = 1'b0;
        o_count_en     = 1'b0;
        o_h_sel        = 1'b0;
        o_wr_en        = 1'b0;
        o_rd_en        = 1'b0;
        o_trigger      = 1'b0;
        o_hbusreq      = 1'b0;
        o_htrans       = HtIdle;
        o_hwrite       = 1'b0;
        o_done_irq     = 1'b0;
        o_err_irq      = 1'b0;
        o_busy         = (r_state != StIdle);

        unique case (r_state)
            StIdle: begin
                if (i_channel_en && !r_en_prev) begin
                    w_state_nxt = StConfig;
                end
            end
            StConfig: begin
                o_s_en      = 1'b1;
                o_d_en      = 1'b1;
                o_ts_en     = 1'b1;
                o_sz_en     = 1'b1;
                o_burst_en  = 1'b1;
                o_s_sel     = 1'b1;
                o_d_sel     = 1'b1;
                o_t_sel     = 1'b1;
                w_state_nxt = StCheck;
            end
            StCheck: begin
                if (i_ts0) begin
                    w_state_nxt = StDone;
                end else if (i_tslb && !r_single) begin
                    // Remainder smaller than a burst: drop to single-beat transfers.
                    o_burst_en   = 1'b1;
                    o_b_sel      = 1'b1;
                    w_single_nxt = 1'b1;
                end else begin
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                o_hbusreq = 1'b1;
                if (i_hgrant) begin
                    w_state_nxt    = StRead;
                    w_beat_cnt_nxt = w_beat_len;
                    w_first_nxt    = 1'b1;
                end
            end
            StRead: begin
                o_hbusreq = 1'b1;
                if (w_rd_beat) begin
                    o_wr_en        = 1'b1;
                    o_s_en         = 1'b1;
                    o_count_en     = 1'b1;
                    o_htrans       = r_first ? HtNonseq : HtSeq;
                    w_first_nxt    = 1'b0;
                    w_beat_cnt_nxt = r_beat_cnt - 5'd1;
                    if (r_beat_cnt == 5'd1) begin
                        w_state_nxt    = StWrite;
                        w_beat_cnt_nxt = w_beat_len;
                        w_first_nxt    = 1'b1;
                    end
                end
                if (w_err) begin
                    w_state_nxt = StError;
                end
            end
            StWrite: begin
                o_hbusreq = 1'b1;
                o_h_sel   = 1'b1;
                o_hwrite  = 1'b1;
                o_trigger = 1'b1;
                if (w_wr_beat) begin
                    o_rd_en        = 1'b1;
                    o_d_en         = 1'b1;
                    o_count_en     = 1'b1;
                    o_htrans       = r_first ? HtNonseq : HtSeq;
                    w_first_nxt    = 1'b0;
                    w_beat_cnt_nxt = r_beat_cnt - 5'd1;
                    if (r_beat_cnt == 5'd1) begin
                        w_state_nxt = StUpdate;
                    end
                end
                if (w_err) begin
                    w_state_nxt = StError;
                end
            end
            StUpdate: begin
                o_ts_en     = 1'b1;
                w_state_nxt = StCheck;
            end
            StDone: begin
                o_done_irq   = 1'b1;
                w_single_nxt = 1'b0;
                w_state_nxt  = StIdle;
            end
            StError: begin
`ifdef DMAC_CHCTRL_ERR_EN
                o_err_irq = 1'b1;
`endif
                if (!i_channel_en) begin
                    w_single_nxt = 1'b0;
                    w_state_nxt  = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_dmac_channel_ctrl.sv
// Directed self-checking bench for dmac_channel_ctrl; every cycle compares the full packed
// output vector against a hand-built expectation.
module tb_dmac_channel_ctrl;

    logic       clk = 1'b0;
    logic       rst, channel_en, bs0, tslb, ts0, fifo_full, fifo_empty;
    logic [2:0] mburst_size;
    logic       hgrant, hready, hresp;
    logic       s_sel, d_sel, b_sel, t_sel, s_en, d_en, ts_en, sz_en, burst_en, count_en;
    logic       h_sel, wr_en, rd_en, trigger, hbusreq, hwrite, busy, done_irq, err_irq;
    logic [1:0] htrans;

    int checks    = 0;
    int failures  = 0;
    int wr_pulses = 0;

    always #5 clk = ~clk;

    dmac_channel_ctrl u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_channel_en  (channel_en),
        .i_bs0         (bs0),
        .i_tslb        (tslb),
        .i_ts0         (ts0),
        .i_fifo_full   (fifo_full),
        .i_fifo_empty  (fifo_empty),
        .i_mburst_size (mburst_size),
        .i_hgrant      (hgrant),
        .i_hready      (hready),
        .i_hresp       (hresp),
        .o_s_sel       (s_sel),
        .o_d_sel       (d_sel),
        .o_b_sel       (b_sel),
        .o_t_sel       (t_sel),
        .o_s_en        (s_en),
        .o_d_en        (d_en),
        .o_ts_en       (ts_en),
        .o_sz_en       (sz_en),
        .o_burst_en    (burst_en),
        .o_count_en    (count_en),
        .o_h_sel       (h_sel),
        .o_wr_en       (wr_en),
        .o_rd_en       (rd_en),
        .o_trigger     (trigger),
        .o_hbusreq     (hbusreq),
        .o_htrans      (htrans),
        .o_hwrite      (hwrite),
        .o_busy        (busy),
        .o_done_irq    (done_irq),
        .o_err_irq     (err_irq)
    );

    // Bit positions of the packed output vector.
    localparam logic [20:0] S_SEL    = 21'h100000;
    localparam logic [20:0] D_SEL    = 21'h080000;
    localparam logic [20:0] B_SEL    = 21'h040000;
    localparam logic [20:0] T_SEL    = 21'h020000;
    localparam logic [20:0] S_EN     = 21'h010000;
    localparam logic [20:0] D_EN     = 21'h008000;
    localparam logic [20:0] TS_EN    = 21'h004000;
    localparam logic [20:0] SZ_EN    = 21'h002000;
    localparam logic [20:0] BURST_EN = 21'h001000;
    localparam logic [20:0] CNT_EN   = 21'h000800;
    localparam logic [20:0] H_SEL    = 21'h000400;
    localparam logic [20:0] WR_EN    = 21'h000200;
    localparam logic [20:0] RD_EN    = 21'h000100;
    localparam logic [20:0] TRIG     = 21'h000080;
    localparam logic [20:0] HBUSREQ  = 21'h000040;
    localparam logic [20:0] HT_NSEQ  = 21'h000020;
    localparam logic [20:0] HT_SEQ   = 21'h000030;
    localparam logic [20:0] HWRITE   = 21'h000008;
    localparam logic [20:0] BUSY     = 21'h000004;
    localparam logic [20:0] DONE     = 21'h000002;
    localparam logic [20:0] ERR      = 21'h000001;

    localparam logic [20:0] CFG      = S_EN | D_EN | TS_EN | SZ_EN | BURST_EN |
                                       S_SEL | D_SEL | T_SEL | BUSY;
    localparam logic [20:0] CHK      = BUSY;
    localparam logic [20:0] REQ      = BUSY | HBUSREQ;
    localparam logic [20:0] RD_STALL = BUSY | HBUSREQ;
    localparam logic [20:0] RD_BEAT  = BUSY | HBUSREQ | WR_EN | S_EN | CNT_EN;
    localparam logic [20:0] WR_BASE  = BUSY | HBUSREQ | H_SEL | HWRITE | TRIG;
    localparam logic [20:0] WR_BEAT  = WR_BASE | RD_EN | D_EN | CNT_EN;
    localparam logic [20:0] UPD      = BUSY | TS_EN;
    localparam logic [20:0] DN       = BUSY | DONE;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle (inputs already applied), then advance one clock.
    task automatic cyc(input string tag, input logic [20:0] exp);
        logic [20:0] obs;
        #1;
        obs = {s_sel, d_sel, b_sel, t_sel, s_en, d_en, ts_en, sz_en, burst_en, count_en,
               h_sel, wr_en, rd_en, trigger, hbusreq, htrans, hwrite, busy, done_irq, err_irq};
        check_eq(tag, {11'b0, obs}, {11'b0, exp});
        if (wr_en === 1'b1) wr_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        channel_en = 1'b0;
        cyc("idle_pre", 21'h0);
        channel_en = 1'b1;
        cyc("idle_edge", 21'h0);
        cyc("config", CFG);
    endtask

    task automatic rd_burst(input int n);
        for (int i = 0; i < n; i++) cyc("rd_beat", RD_BEAT | ((i == 0) ? HT_NSEQ : HT_SEQ));
    endtask

    task automatic wr_burst(input int n);
        for (int i = 0; i < n; i++) cyc("wr_beat", WR_BEAT | ((i == 0) ? HT_NSEQ : HT_SEQ));
    endtask

    task automatic finish_run();
        cyc("update", UPD);
        ts0 = 1'b1;
        cyc("check_ts0", CHK);
        ts0 = 1'b0;
        cyc("done", DN);
        cyc("idle_post", 21'h0);
    endtask

    initial begin
        rst = 1'b1; channel_en = 1'b0; bs0 = 1'b0; tslb = 1'b0; ts0 = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b0; mburst_size = 3'b000;
        hgrant = 1'b0; hready = 1'b1; hresp = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", 21'h0);
        cyc("reset1", 21'h0);
        rst = 1'b0;

        // Two 4-beat read/write pairs, then done; held channel_en must not restart.
        mburst_size = 3'b001; hgrant = 1'b1;
        start_run();
        cyc("check", CHK);
        cyc("req", REQ);
        rd_burst(4);
        wr_burst(4);
        cyc("update", UPD);
        cyc("check2", CHK);
        cyc("req2", REQ);
        rd_burst(4);
        wr_burst(4);
        finish_run();
        cyc("idle_level", 21'h0);

        // Remainder below burst size: single-beat mode, grant delayed one cycle.
        tslb = 1'b1; hgrant = 1'b0;
        start_run();
        cyc("check_tslb", CHK | BURST_EN | B_SEL);
        cyc("check_single", CHK);
        cyc("req_wait", REQ);
        hgrant = 1'b1;
        cyc("req_grant", REQ);
        rd_burst(1);
        wr_burst(1);
        finish_run();
        tslb = 1'b0;

        // hready low for three cycles on read beat 2.
        wr_pulses = 0;
        start_run();
        cyc("check", CHK);
        cyc("req", REQ);
        cyc("rd1", RD_BEAT | HT_NSEQ);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rd_stall", RD_STALL);
        hready = 1'b1;
        cyc("rd2", RD_BEAT | HT_SEQ);
        cyc("rd3", RD_BEAT | HT_SEQ);
        cyc("rd4", RD_BEAT | HT_SEQ);
        wr_burst(4);
        finish_run();
        check_eq("wr_pulses", wr_pulses, 4);

        // FIFO guards: full stalls read, empty stalls write.
        mburst_size = 3'b000;
        start_run();
        cyc("check", CHK);
        cyc("req", REQ);
        fifo_full = 1'b1;
        cyc("rd_full", RD_STALL);
        fifo_full = 1'b0;
        cyc("rd1", RD_BEAT | HT_NSEQ);
        fifo_empty = 1'b1;
        cyc("wr_empty0", WR_BASE);
        cyc("wr_empty1", WR_BASE);
        fifo_empty = 0;
        cyc("wr1", WR_BEAT | HT_NSEQ);
        finish_run();

        // Error response on write beat 3.
        mburst_size = 3'b001;
        start_run();
        cyc("check", CHK);
        cyc("req", REQ);
        rd_burst(4);
        cyc("wr1", WR_BEAT | HT_NSEQ);
        cyc("wr2", WR_BEAT | HT_SEQ);
        hresp = 1'b1;
        cyc("wr3_hresp", WR_BEAT | HT_SEQ);
        hresp = 1'b0;
`ifdef DMAC_CHCTRL_ERR_EN
        cyc("err0", BUSY | ERR);
        cyc("err1", BUSY | ERR);
        channel_en = 1'b0;
        cyc("err_exit", BUSY | ERR);
        cyc("err_idle", 21'h0);
`else
        cyc("wr4", WR_BEAT | HT_SEQ);
        finish_run();
`endif

        // Synchronous reset during read beat 3 of an 8-beat burst.
        mburst_size = 3'b010;
        start_run();
        cyc("check", CHK);
        cyc("req", REQ);
        cyc("rd1", RD_BEAT | HT_NSEQ);
        cyc("rd2", RD_BEAT | HT_SEQ);
        rst = 1'b1; channel_en = 1'b0;
        cyc("rd3_rst", RD_BEAT | HT_SEQ);
        rst = 1'b0;
        cyc("after_rst0", 21'h0);
        cyc("after_rst1", 21'h0);

        // Fresh run after reset uses the newly loaded beat count.
        mburst_size = 3'b000;
        start_run();
        cyc("check", CHK);
        cyc("req", REQ);
        rd_burst(1);
        wr_burst(1);
        finish_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
